// File: rtl/inc_pulse_ctrl_if.sv
// Button-side signal bundle for inc_pulse_ctrl: raw button in, increment pulse and status out.
// master = board/button side, slave = controller.
interface inc_pulse_ctrl_if;
  logic btn;
  logic inc;
  logic btn_db;
  logic busy;

  modport master (output btn, input inc, btn_db, busy);
  modport slave (input btn, output inc, btn_db, busy);
endinterface

// File: rtl/inc_pulse_ctrl.sv
// Debounces a raw push-button and emits one single-cycle inc pulse per accepted press.
// Optional auto-repeat while held is enabled by defining INC_AUTO_REPEAT_EN.
module inc_pulse_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input logic            clk,
  input logic            reset,
  inc_pulse_ctrl_if.slave bus
);

  localparam int unsigned TmrW = $clog2(DEBOUNCE_CYCLES);
  // The sample that leaves IDLE/PRESSED counts as the first stable sample.
  localparam logic [TmrW-1:0] TmrLast = TmrW'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be 2 or more");
  end
  if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_repeat
    $error("HOLD_CYCLES and REPEAT_CYCLES must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StWaitPress, StPressed, StWaitRelease} state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            sync1_q, btn_s;
  logic            press_inc, rpt_inc;
  logic            inc_q, btn_db_q, busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync1_q <= bus.btn;
      btn_s   <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    press_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) state_d = StWaitPress;
      end
      StWaitPress: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (tmr_q == TmrLast) begin
          state_d   = StPressed;
          press_inc = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StPressed: begin
        if (!btn_s) state_d = StWaitRelease;
      end
      StWaitRelease: begin
        if (btn_s) begin
          state_d = StPressed;
        end else if (tmr_q == TmrLast) begin
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

`ifdef INC_AUTO_REPEAT_EN
  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;
  localparam logic [RptW-1:0] HoldLast   = RptW'(HOLD_CYCLES - 1);
  localparam logic [RptW-1:0] RepeatLast = RptW'(REPEAT_CYCLES - 1);

  logic [RptW-1:0] rpt_q, rpt_d;
  logic            rep_q, rep_d;  // first (hold) pulse already issued

  always_comb begin
    rpt_d   = '0;
    rep_d   = 1'b0;
    rpt_inc = 1'b0;
    if (state_q == StPressed && state_d == StPressed) begin
      rep_d = rep_q;
      rpt_d = rpt_q + 1'b1;
      if (rep_q ? (rpt_q == RepeatLast) : (rpt_q == HoldLast)) begin
        rpt_inc = 1'b1;
        rpt_d   = '0;
        rep_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      rep_q <= rep_d;
    end
  end
`else
  assign rpt_inc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      inc_q    <= 1'b0;
      btn_db_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      inc_q    <= press_inc | rpt_inc;
      btn_db_q <= (state_d == StPressed) || (state_d == StWaitRelease);
      busy_q   <= (state_d == StWaitPress) || (state_d == StWaitRelease);
    end
  end

  assign bus.inc    = inc_q;
  assign bus.btn_db = btn_db_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_inc_pulse_ctrl.sv
// Directed self-checking bench for inc_pulse_ctrl (DEBOUNCE=4, HOLD=8, REPEAT=4).
// Edge k counts rising edges from the first edge that samples the new button level.
module tb_inc_pulse_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  inc_pulse_ctrl_if bus ();

  inc_pulse_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .REPEAT_CYCLES  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.btn = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.btn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL reset k=%0d {inc,btn_db,busy}=%b expected 000", k,
                 {bus.inc, bus.btn_db, bus.busy});
      end
    end
    reset   = 1'b0;
    bus.btn = 1'b0;
    repeat (6) step();
    checks++;
    if ({bus.inc, bus.btn_db, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle {inc,btn_db,busy}=%b expected 000",
               {bus.inc, bus.btn_db, bus.busy});
    end
  endtask

  task automatic test_clean_press();
    logic e_inc, e_db, e_busy;
    bus.btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      e_inc  = (k == 6);
      e_db   = (k >= 6);
      e_busy = (k >= 3 && k <= 5);
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {e_inc, e_db, e_busy}) begin
        failures++;
        $display("FAIL clean_press k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {e_inc, e_db, e_busy});
      end
    end
    bus.btn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      e_db   = (k < 6);
      e_busy = (k >= 3 && k <= 5);
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {1'b0, e_db, e_busy}) begin
        failures++;
        $display("FAIL clean_release k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {1'b0, e_db, e_busy});
      end
    end
  endtask

  task automatic test_bouncy_press();
    logic e_inc, e_db, e_busy;
    for (int k = 1; k <= 16; k++) begin
      bus.btn = (k == 1 || k == 3 || k >= 5);
      step();
      e_inc  = (k == 10);
      e_db   = (k >= 10);
      e_busy = (k == 3 || k == 5 || (k >= 7 && k <= 9));
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {e_inc, e_db, e_busy}) begin
        failures++;
        $display("FAIL bouncy_press k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {e_inc, e_db, e_busy});
      end
    end
    go_idle();
  endtask

  task automatic test_release_bounce();
    logic e_db, e_busy;
    bus.btn = 1'b1;
    repeat (10) step();
    checks++;
    if (bus.btn_db !== 1'b1) begin
      failures++;
      $display("FAIL release_bounce_pressed btn_db=%b expected 1", bus.btn_db);
    end
    for (int k = 1; k <= 12; k++) begin
      bus.btn = (k == 3);
      step();
      e_db   = (k < 9);
      e_busy = (k == 3 || k == 4 || (k >= 6 && k <= 8));
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {1'b0, e_db, e_busy}) begin
        failures++;
        $display("FAIL release_bounce k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {1'b0, e_db, e_busy});
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic e_inc, e_db, e_busy;
    bus.btn = 1'b1;
    repeat (4) step();
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_press_wait busy=%b expected 1", bus.busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({bus.inc, bus.btn_db, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_press_reset {inc,btn_db,busy}=%b expected 000",
               {bus.inc, bus.btn_db, bus.busy});
    end
    for (int k = 1; k <= 10; k++) begin
      step();
      e_inc  = (k == 6);
      e_db   = (k >= 6);
      e_busy = (k >= 3 && k <= 5);
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {e_inc, e_db, e_busy}) begin
        failures++;
        $display("FAIL mid_press_after k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {e_inc, e_db, e_busy});
      end
    end
    go_idle();
  endtask

  task automatic test_glitch();
    logic e_busy;
    for (int k = 1; k <= 10; k++) begin
      bus.btn = (k <= 3);
      step();
      e_busy = (k >= 3 && k <= 5);
      checks++;
      if ({bus.inc, bus.btn_db, bus.busy} !== {1'b0, 1'b0, e_busy}) begin
        failures++;
        $display("FAIL glitch k=%0d {inc,btn_db,busy}=%b expected %b", k,
                 {bus.inc, bus.btn_db, bus.busy}, {1'b0, 1'b0, e_busy});
      end
    end
  endtask

  task automatic test_long_hold();
    logic e_inc;
    int   pulses;
    pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      bus.btn = (k <= 30);
      step();
`ifdef INC_AUTO_REPEAT_EN
      e_inc = (k == 6 || k == 14 || k == 18 || k == 22 || k == 26 || k == 30);
`else
      e_inc = (k == 6);
`endif
      if (bus.inc === 1'b1) pulses++;
      checks++;
      if (bus.inc !== e_inc) begin
        failures++;
        $display("FAIL long_hold k=%0d inc=%b expected %b", k, bus.inc, e_inc);
      end
    end
    checks++;
`ifdef INC_AUTO_REPEAT_EN
    if (pulses !== 6) begin
      failures++;
      $display("FAIL long_hold_count pulses=%0d expected 6", pulses);
    end
`else
    if (pulses !== 1) begin
      failures++;
      $display("FAIL long_hold_count pulses=%0d expected 1", pulses);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.btn  = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release_bounce();
    test_reset_mid_press();
    test_glitch();
    test_long_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
